water_inlet_arbiter: RTL and testbench
======================================

Name: water_inlet_arbiter

Overview:
- Shares one mains water inlet valve among N washing-machine controllers.
- Each controller raises its fill valve request; the arbiter grants the inlet to one machine at a time, round-robin.
- The arbiter holds the inlet open until that machine reports filled, drops its request, or exceeds a fill-time limit.
- It sits between the per-machine FSMs' fillvalve_on/filled signals and the physical inlet valve driver.

Parameters:
- N, 4, number of requesting machines (2..8).
- MAX_FILL, 64, maximum cycles a single grant may keep the inlet open before timeout (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fill_req  input  N  per-machine fill request (bit i = machine i fillvalve_on).
- filled  input  N  per-machine water-level-reached flag.
- grant  output  N  one-hot inlet grant; all zero when no grant.
- grant_id  output  $clog2(N)  index of the granted machine; 0 when idle.
- inlet_open  output  1  drive to shared inlet valve; high only in FILL.
- fill_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
- fault_mask  output  N  machines currently locked out after a timeout.

Behaviour:
- All outputs registered. Reset (async, rst=1): state=IDLE, grant=0, grant_id=0, inlet_open=0, fill_timeout=0, fault_mask=0, rr pointer=0, fill_cnt=0.
- eligible = fill_req & ~fault_mask.
- States: IDLE, FILL, RELEASE.
- IDLE:
  - If eligible==0, stay.
  - Otherwise the winner is the first set bit of eligible, searching from ptr upward with wrap mod N.
  - Next edge: state=FILL, grant=onehot(winner), grant_id=winner, inlet_open=1, fill_cnt=0, ptr=(winner+1) mod N.
- FILL, evaluated each cycle, in priority order:
  - (a) filled[grant_id]=1 -> RELEASE (normal completion).
  - (b) fill_req[grant_id]=0 -> RELEASE (abort, no fault).
  - (c) fill_cnt==MAX_FILL-1 -> RELEASE, fault_mask[grant_id] set, fill_timeout=1 for the following cycle only.
  - (d) else fill_cnt++.
  - Consequence: inlet_open is high for at most MAX_FILL consecutive cycles per grant.
- RELEASE:
  - grant=0, grant_id=0, inlet_open=0 for exactly one cycle, then IDLE.
  - Guarantees a valve-closed gap between grants. Minimum spacing between two grants is 2 closed cycles (RELEASE + IDLE arbitration).
- Requests from non-granted machines never affect the current grant: no preemption.
- fill_cnt width = $clog2(MAX_FILL); it never wraps because (c) fires first.
- fault_mask[i]:
  - Cleared on any cycle where fill_req[i]=0.
  - If set and cleared conditions coincide for the same bit, set wins (cannot occur in practice, since (b) precedes (c)).
  - A masked machine must drop and re-raise its request to be served again.
- filled bits of non-granted machines are ignored.
- Reset mid-FILL closes the inlet immediately (asynchronous) and clears fault_mask and ptr.
- Simultaneous requests in IDLE: exactly one grant. Fairness: a continuously requesting machine is granted within N grants.

Test Plan (N=4, MAX_FILL=8):
- Reset: assert rst mid-FILL with grant=0010 -> grant=0000, inlet_open=0, fault_mask=0000 asynchronously; after release, with fill_req=0000, state stays IDLE.
- Single request: fill_req=0100 at cycle 0 -> cycle 1 grant=0100, grant_id=2, inlet_open=1; filled[2]=1 at cycle 4 -> cycle 5 inlet_open=0, grant=0000; cycle 6 IDLE.
- Round-robin: fill_req=1111 held, each machine gets filled 3 cycles after its grant -> grant order 0001, 0010, 0100, 1000, 0001, with inlet_open=0 for exactly 2 cycles between grants.
- Timeout: fill_req=0001, filled=0 -> inlet_open high for exactly 8 cycles, then fill_timeout=1 for one cycle and fault_mask=0001; no regrant while fill_req[0] held; drop fill_req[0] for one cycle then re-raise -> fault_mask cleared and machine 0 regranted.
- Abort and mask bypass: grant machine 1 with fill_req=0011; drop fill_req[1] at cnt=3 -> RELEASE with no fill_timeout; next grant goes to machine 0 (ptr=2 wraps to 0); with fault_mask=0100 and fill_req=0100 -> no grant.
- Ignored signals: with machine 3 granted, pulse filled[1]=1 and raise fill_req[0] -> grant=1000 unchanged and fill_cnt keeps counting.

Source files
------------

// File: rtl/water_inlet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : water_inlet_arbiter
// Purpose  : Round-robin owner of the shared mains inlet valve across N
//            washing-machine controllers, with fill timeout and lockout.
// Revision : 1.0 - initial release
// ============================================================================
module water_inlet_arbiter #(
    parameter int N        = 4,
    parameter int MAX_FILL = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         fill_req,
    input  logic [N-1:0]         filled,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 inlet_open,
    output logic                 fill_timeout,
    output logic [N-1:0]         fault_mask
);

    localparam int c_idw = $clog2(N);
    localparam int c_cw  = $clog2(MAX_FILL);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(MAX_FILL - 1);
    localparam logic [N-1:0]    c_one      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_grant;
    logic [c_idw-1:0] r_grant_id;
    logic             r_inlet_open;
    logic             r_fill_timeout;
    logic [N-1:0]     r_fault_mask;
    logic [c_idw-1:0] r_ptr;
    logic [c_cw-1:0]  r_fill_cnt;

    logic [N-1:0]     w_eligible;
    logic             w_any;
    logic [c_idw-1:0] w_cand;
    logic [c_idw-1:0] w_winner;
    logic [c_idw-1:0] w_next_ptr;

    // Index addition modulo N; N need not be a power of two.
    function automatic logic [c_idw-1:0] wrap_add(input logic [c_idw-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N)
            s = s - N;
        return c_idw'(s);
    endfunction

    assign w_eligible = fill_req & ~r_fault_mask;

    // First eligible machine at or after the round-robin pointer.
    always_comb begin
        w_any      = 1'b0;
        w_cand     = '0;
        w_winner   = '0;
        w_next_ptr = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = wrap_add(r_ptr, k);
            if (!w_any && w_eligible[w_cand]) begin
                w_any      = 1'b1;
                w_winner   = w_cand;
                w_next_ptr = wrap_add(w_cand, 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_grant_id     <= '0;
            r_inlet_open   <= 1'b0;
            r_fill_timeout <= 1'b0;
            r_fault_mask   <= '0;
            r_ptr          <= '0;
            r_fill_cnt     <= '0;
        end else begin
            r_fill_timeout <= 1'b0;
            r_fault_mask   <= r_fault_mask & fill_req;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_FILL;
                        r_grant      <= c_one << w_winner;
                        r_grant_id   <= w_winner;
                        r_inlet_open <= 1'b1;
                        r_fill_cnt   <= '0;
                        r_ptr        <= w_next_ptr;
                    end
                end
                S_FILL: begin
                    if (filled[r_grant_id] || !fill_req[r_grant_id]) begin
                        r_state      <= S_RELEASE;
                        r_grant      <= '0;
                        r_grant_id   <= '0;
                        r_inlet_open <= 1'b0;
                    end else if (r_fill_cnt == c_cnt_last) begin
                        r_state        <= S_RELEASE;
                        r_grant        <= '0;
                        r_grant_id     <= '0;
                        r_inlet_open   <= 1'b0;
                        r_fill_timeout <= 1'b1;
                        // Lockout set overrides the same-cycle clear above.
                        r_fault_mask   <= (r_fault_mask & fill_req) | r_grant;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign grant_id     = r_grant_id;
    assign inlet_open   = r_inlet_open;
    assign fill_timeout = r_fill_timeout;
    assign fault_mask   = r_fault_mask;

endmodule
`default_nettype wire

// File: tb/tb_water_inlet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_water_inlet_arbiter
// Purpose  : Directed self-checking bench for water_inlet_arbiter (N=4, MAX_FILL=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_water_inlet_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] fill_req;
    logic [3:0] filled;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       inlet_open;
    logic       fill_timeout;
    logic [3:0] fault_mask;

    int checks;
    int errors;

    water_inlet_arbiter #(
        .N        (4),
        .MAX_FILL (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fill_req     (fill_req),
        .filled       (filled),
        .grant        (grant),
        .grant_id     (grant_id),
        .inlet_open   (inlet_open),
        .fill_timeout (fill_timeout),
        .fault_mask   (fault_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fill_req = 4'b0000; filled = 4'b0000;
        tick(); tick();
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0 || grant_id !== 2'd0 ||
            fill_timeout !== 1'b0 || fault_mask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: grant=%b id=%0d open=%b to=%b mask=%b, expected all zero",
                     grant, grant_id, inlet_open, fill_timeout, fault_mask);
        end
        rst = 1'b0;
        fill_req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || inlet_open !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: grant=%b open=%b, expected 0010 1", grant, inlet_open);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0 || fault_mask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: grant=%b open=%b mask=%b, expected 0000 0 0000",
                     grant, inlet_open, fault_mask);
        end
        fill_req = 4'b0000;
        tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: grant=%b open=%b, expected 0000 0", grant, inlet_open);
        end
    endtask

    task automatic test_single();
        fill_req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || inlet_open !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b id=%0d open=%b, expected 0100 2 1",
                     grant, grant_id, inlet_open);
        end
        tick(); tick(); tick();
        filled = 4'b0100;
        tick();
        filled = 4'b0000; fill_req = 4'b0000;
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0 || fill_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%b open=%b to=%b, expected 0000 0 0",
                     grant, inlet_open, fill_timeout);
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: grant=%b open=%b, expected 0000 0", grant, inlet_open);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        apply_reset();
        fill_req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant !== order[i] || inlet_open !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant_%0d: grant=%b open=%b, expected %b 1",
                         i, grant, inlet_open, order[i]);
            end
            tick(); tick(); tick();
            filled = order[i];
            tick();
            filled = 4'b0000;
            checks++;
            if (inlet_open !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap1_%0d: open=%b, expected 0", i, inlet_open);
            end
            tick();
            checks++;
            if (inlet_open !== 1'b0 || grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap2_%0d: open=%b grant=%b, expected 0 0000", i, inlet_open, grant);
            end
            tick();
        end
        fill_req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        fill_req = 4'b0001; filled = 4'b0000;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (inlet_open !== 1'b1 || fill_timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_open_c%0d: open=%b to=%b, expected 1 0", c, inlet_open, fill_timeout);
            end
            if (c < 8) tick();
        end
        tick();
        checks++;
        if (inlet_open !== 1'b0 || fill_timeout !== 1'b1 || fault_mask !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_fire: open=%b to=%b mask=%b, expected 0 1 0001",
                     inlet_open, fill_timeout, fault_mask);
        end
        tick();
        checks++;
        if (fill_timeout !== 1'b0 || fault_mask !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_pulse_width: to=%b mask=%b, expected 0 0001", fill_timeout, fault_mask);
        end
        tick(); tick();
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_regrant: grant=%b open=%b, expected 0000 0", grant, inlet_open);
        end
        fill_req = 4'b0000;
        tick();
        checks++;
        if (fault_mask !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_mask_clear: mask=%b, expected 0000", fault_mask);
        end
        fill_req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || inlet_open !== 1'b1) begin
            errors++;
            $display("FAIL timeout_regrant: grant=%b open=%b, expected 0001 1", grant, inlet_open);
        end
        fill_req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_abort_mask();
        fill_req = 4'b0011;
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL abort_grant: grant=%b id=%0d, expected 0010 1", grant, grant_id);
        end
        tick(); tick(); tick();
        fill_req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0000 || inlet_open !== 1'b0 || fill_timeout !== 1'b0 || fault_mask !== 4'b0000) begin
            errors++;
            $display("FAIL abort_release: grant=%b open=%b to=%b mask=%b, expected 0000 0 0 0000",
                     grant, inlet_open, fill_timeout, fault_mask);
        end
        tick(); tick();
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL abort_wrap_grant: grant=%b id=%0d, expected 0001 0", grant, grant_id);
        end
        fill_req = 4'b0000;
        tick(); tick();
        fill_req = 4'b0100;
        for (int c = 0; c < 9; c++) tick();
        checks++;
        if (fault_mask !== 4'b0100 || fill_timeout !== 1'b1) begin
            errors++;
            $display("FAIL mask_set: mask=%b to=%b, expected 0100 1", fault_mask, fill_timeout);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0000 || inlet_open !== 1'b0) begin
                errors++;
                $display("FAIL mask_blocks_%0d: grant=%b open=%b, expected 0000 0", c, grant, inlet_open);
            end
        end
        fill_req = 4'b0000;
        tick();
    endtask

    task automatic test_ignored();
        fill_req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL ignore_grant: grant=%b id=%0d, expected 1000 3", grant, grant_id);
        end
        tick();
        filled = 4'b0010; fill_req = 4'b1001;
        tick();
        filled = 4'b0000;
        checks++;
        if (grant !== 4'b1000 || inlet_open !== 1'b1) begin
            errors++;
            $display("FAIL ignore_hold: grant=%b open=%b, expected 1000 1", grant, inlet_open);
        end
        for (int c = 4; c <= 8; c++) tick();
        checks++;
        if (grant !== 4'b1000 || fill_timeout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_still_open: grant=%b to=%b, expected 1000 0", grant, fill_timeout);
        end
        tick();
        checks++;
        if (fill_timeout !== 1'b1 || inlet_open !== 1'b0 || fault_mask !== 4'b1000) begin
            errors++;
            $display("FAIL ignore_timeout: to=%b open=%b mask=%b, expected 1 0 1000",
                     fill_timeout, inlet_open, fault_mask);
        end
        tick(); tick();
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL ignore_next_grant: grant=%b id=%0d, expected 0001 0", grant, grant_id);
        end
        fill_req = 4'b0000;
        tick(); tick(); tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort_mask();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
